// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - request/result and shared-ALU signal bundle for alu_mul_seq
//
// Signals:
//   start, op_a, op_b         multiply request from the EX stage
//   stall, done, hi_out, lo_out  pipeline stall, one-cycle done pulse, product HI/LO
//   alu_sel, alu_signal,      drive into the shared EX ALU input mux
//   alu_a, alu_b
//   alu_out                   combinational result returned by the shared ALU
// Modports:
//   master - EX stage / ALU side
//   slave  - the multiply sequencer
interface alu_mul_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        alu_sel;
    logic [2:0]  alu_signal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op_a, op_b, alu_out,
        input  alu_sel, alu_signal, alu_a, alu_b, stall, done, hi_out, lo_out
    );

    modport slave (
        input  start, op_a, op_b, alu_out,
        output alu_sel, alu_signal, alu_a, alu_b, stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned 32x32->64 shift-add multiplier borrowing the shared EX ALU
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_mul_seq_if.slave (start/op_a/op_b in, stall/done/hi_out/lo_out out,
//          alu_sel/alu_signal/alu_a/alu_b out to the shared ALU, alu_out back)
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operand finishes in one cycle)
module alu_mul_seq (
    input  logic         clk,
    input  logic         reset,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b000;

    state_t      state;
    state_t      state_next;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [4:0]  cnt;
    logic        accept;
    logic        zero_op;
    logic [31:0] sum;
    logic        carry;

    // A new request is taken in IDLE and also in DONE, allowing back-to-back multiplies.
    assign accept = (state == IDLE || state == DONE) && bus.start;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // The ALU has no carry-out: an unsigned add overflowed exactly when the sum wrapped below hi.
    assign sum   = bus.alu_out;
    assign carry = (sum < hi);

    assign bus.alu_a  = hi;
    assign bus.alu_b  = mcand & {32{lo[0]}};
    assign bus.stall  = (state == IDLE && bus.start) || (state == RUN);
    assign bus.done   = (state == DONE);
    // hi/lo are untouched outside RUN, so the result stays visible until the next accepted start.
    assign bus.hi_out = hi;
    assign bus.lo_out = lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.alu_sel    = 1'b0;
        bus.alu_signal = ALU_NOP;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = zero_op ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                bus.alu_sel    = 1'b1;
                bus.alu_signal = ALU_ADD;
                if (cnt == 5'd31) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (accept) begin
            hi    <= '0;
            lo    <= zero_op ? 32'd0 : bus.op_b;
            mcand <= bus.op_a;
            cnt   <= '0;
        end else if (state == RUN) begin
            // {carry, sum, lo} shifted right by one; the consumed multiplier bit drops off lo[0].
            {hi, lo} <= {carry, sum, lo[31:1]};
            cnt      <= cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_mul_seq_if bus();

    alu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the shared EX ALU: ADD on 3'b010, something different otherwise.
    assign bus.alu_out = (bus.alu_signal == 3'b010) ? (bus.alu_a + bus.alu_b)
                                                    : (bus.alu_a ^ bus.alu_b);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int sel_violations = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) done_count++;
            if (bus.alu_signal !== (bus.alu_sel ? 3'b010 : 3'b000)) sel_violations++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for done starting from cycle 1; returns the cycle index at which done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    function automatic int expected_latency(input logic [31:0] a, input logic [31:0] b);
        int l;
        l = 33;
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) l = 1;
`endif
        return l;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_prod, input string name);
        int exp_lat;
        int lat;
        int stall_cycles;
        int sel_cycles;
        exp_lat = expected_latency(a, b);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        #1;
        stall_cycles = bus.stall ? 1 : 0;
        sel_cycles = 0;
        tick;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (bus.stall) stall_cycles++;
            if (bus.alu_sel) sel_cycles++;
            tick;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " product"}, {bus.hi_out, bus.lo_out}, exp_prod);
        check({name, " stall cycles"}, 64'(stall_cycles), 64'(exp_lat));
        check({name, " alu_sel cycles"}, 64'(sel_cycles), 64'(exp_lat - 1));
        check({name, " stall at done"}, 64'(bus.stall), 64'd0);
        tick;
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;
        int dc;

        vecs[0] = '{32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        tick;
        tick;
        check("reset done", 64'(bus.done), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        check("reset alu_sel", 64'(bus.alu_sel), 64'd0);
        check("reset alu_signal", 64'(bus.alu_signal), 64'd0);
        check("reset hi/lo", {bus.hi_out, bus.lo_out}, 64'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_mul(ra, rb, 64'(ra) * 64'(rb), $sformatf("rand%0d", i));
        end

        // Back-to-back: start held high through DONE launches the next multiply.
        bus.op_a  = 32'h8000_0000;
        bus.op_b  = 32'h0000_0002;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b first latency", 64'(lat), 64'd33);
        check("b2b first product", {bus.hi_out, bus.lo_out}, 64'h0000_0001_0000_0000);
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd6;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b second latency", 64'(lat), 64'd33);
        check("b2b second product", {bus.hi_out, bus.lo_out}, 64'd42);
        tick;

        // start during RUN is ignored.
        dc = done_count;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        bus.op_a  = 32'd9;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        lat = 6;
        while (!bus.done && lat < 100) begin
            tick;
            lat++;
        end
        check("run-start latency", 64'(lat), 64'd33);
        check("run-start product", {bus.hi_out, bus.lo_out}, 64'd15);
        repeat (40) tick;
        check("run-start done pulses", 64'(done_count - dc), 64'd1);

        // Reset at cycle 10 aborts the multiply.
        dc = done_count;
        bus.op_a  = 32'h0000_1234;
        bus.op_b  = 32'h0000_5678;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort alu_sel", 64'(bus.alu_sel), 64'd0);
        check("abort stall", 64'(bus.stall), 64'd0);
        check("abort hi/lo", {bus.hi_out, bus.lo_out}, 64'd0);
        repeat (40) tick;
        check("abort done pulses", 64'(done_count - dc), 64'd0);

        // Reset and start in the same cycle: reset wins.
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        reset     = 1'b1;
        tick;
        reset     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("reset+start stall", 64'(bus.stall), 64'd0);
        check("reset+start alu_sel", 64'(bus.alu_sel), 64'd0);
        check("reset+start hi/lo", {bus.hi_out, bus.lo_out}, 64'd0);
        repeat (3) tick;

        check("alu_signal protocol violations", 64'(sel_violations), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 32×32→64 multiply sequencer that reuses the shared 32-bit ripple ALU as its adder, one shift-add iteration per cycle. It sits beside the EX stage, takes ownership of the ALU while a multiply runs, stalls the pipeline, and returns a HI/LO result for the EX stage to write back.

## Interface
- No parameters. Width is fixed at 32.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- op_a  in  32  multiplicand; captured on the accepted start.
- op_b  in  32  multiplier; captured on the accepted start.
- alu_sel  out  1  high means the EX ALU input mux selects this block's alu_* drive.
- alu_signal  out  3  ALU opcode; always 3'b010 (ADD) while alu_sel=1, 3'b000 otherwise.
- alu_a  out  32  ALU operand A = hi register.
- alu_b  out  32  ALU operand B = mcand & {32{lo[0]}}.
- alu_out  in  32  ALU dataOut (combinational return).
- stall  out  1  combinational: (state==IDLE && start) || state==RUN.
- done  out  1  one-cycle pulse; result valid.
- hi_out  out  32  product[63:32]; held until the next accepted start.
- lo_out  out  32  product[31:0]; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE. Registers: hi[31:0], lo[31:0], mcand[31:0], cnt[4:0].
- IDLE: start=1 → hi=0, lo=op_b, mcand=op_a, cnt=0, go to RUN. start=0 → stay.
- RUN (alu_sel=1): sum=alu_out; carry = (sum < hi), unsigned compare inside this block (the ALU exposes no carry-out). Update {hi,lo} = {carry, sum, lo[31:1]} (a 65-bit value shifted right by 1, keeping the low 64 bits). cnt increments. After the iteration with cnt==31, go to DONE.
- DONE: done=1; hi_out/lo_out = hi/lo. start=1 is accepted exactly as in IDLE (back-to-back multiplies); otherwise go to IDLE.
- start in RUN: ignored; no queuing.
- alu_sel=0 in IDLE and DONE, so the EX stage regains the ALU in the DONE cycle.
- Arithmetic is unsigned only. Signed MULT is out of scope for this block.

## Timing
- Reset values: state=IDLE, hi=lo=mcand=0, cnt=0, done=0, stall=0, alu_sel=0, alu_signal=3'b000, hi_out=lo_out=0.
- Cycle 0: start high in IDLE, stall=1 combinationally. Cycles 1–32: RUN, stall=1, 32 iterations. Cycle 33: DONE, done=1, stall=0.
- Latency from start to done is 33 cycles. Throughput with back-to-back starts is one multiply per 33 cycles.
- reset during RUN or DONE: the next state is IDLE with all reset values; the partial product is discarded and no done pulse is issued.
- reset and start in the same cycle: reset wins.
- The ALU path is combinational. alu_out must settle within the same cycle as alu_a/alu_b.

## Configuration
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - An accepted start with op_a==0 or op_b==0 goes directly to DONE with hi=lo=0.
  - done is asserted on cycle 1 (latency 1). stall is high only on cycle 0. alu_sel is never asserted.
- Undefined:
  - Zero operands take the full 33-cycle RUN path.
  - Results are identical either way.

## Test plan
- op_a=3, op_b=5, start pulse at cycle 0 → done at cycle 33, hi_out=0x00000000, lo_out=0x0000000F; stall high cycles 0–32.
- op_a=op_b=0xFFFFFFFF → hi_out=0xFFFFFFFE, lo_out=0x00000001. Exercises the carry on every iteration.
- op_a=0x80000000, op_b=0x00000002 → hi_out=0x00000001, lo_out=0x00000000. Then start held high in DONE with op_a=7, op_b=6 → second done 33 cycles later, lo_out=42.
- Start 3×5; during cycles 1–32 pulse start with op_a=9 → first result is unaffected (lo_out=15), and exactly one done pulse occurs.
- Start 0x1234×0x5678; reset at cycle 10 → state IDLE on cycle 11, done never asserted, hi_out=lo_out=0, alu_sel=0.
- op_a=0, op_b=0xDEADBEEF → with MUL_ZERO_BYPASS_EN: done at cycle 1, alu_sel never high. Without it: done at cycle 33. Both give hi_out=lo_out=0.
